// File: rtl/debugger_tx_serializer.sv
// Purpose: latches a NUM_BYTES debug frame on send_signal and writes it byte 0 first into the UART TX FIFO.
// Latency: byte i is written 1+2i falling edges after send_signal is sampled; data_sent follows 2 edges after the last byte.
// Backpressure: while tx_full is high, no write is issued and the current byte waits in SEND indefinitely.
module debugger_tx_serializer #(
  parameter int NUM_BYTES = 220,
  parameter int IDX_W     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   send_signal,
  input  logic [NUM_BYTES*8-1:0] send_data,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   data_sent,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t                      state;
  logic [NUM_BYTES-1:0][7:0]   shadow;
  logic [IDX_W-1:0]            index;

  // Frame sequencer: all outputs are registered and every register moves on the falling edge.
  // The GAP state after each write leaves a cycle for tx_full to reflect that write.
  always_ff @(negedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      index     <= '0;
      wr_uart   <= 1'b0;
      w_data    <= 8'h00;
      data_sent <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_uart   <= 1'b0;
          data_sent <= 1'b0;
          if (send_signal) begin
            shadow <= send_data;
            index  <= '0;
            busy   <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          data_sent <= 1'b0;
          if (!tx_full) begin
            wr_uart <= 1'b1;
            w_data  <= shadow[index];
            state   <= GAP;
          end else begin
            wr_uart <= 1'b0;
          end
        end
        GAP: begin
          wr_uart <= 1'b0;
          if (index == LAST_IDX) begin
            state <= DONE;
          end else begin
            index <= index + 1'b1;
            state <= SEND;
          end
        end
        DONE: begin
          // A send_signal arriving here is dropped: only IDLE accepts a new frame.
          wr_uart   <= 1'b0;
          data_sent <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          wr_uart   <= 1'b0;
          data_sent <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debugger_tx_serializer.sv
// Bench for debugger_tx_serializer: expected bytes (and, where timed, expected edge numbers)
// are queued when a frame is launched and popped by a monitor whenever the DUT strobes wr_uart.
// Outputs are sampled on the rising edge, away from the DUT's falling active edge.
module tb_debugger_tx_serializer;

  localparam int NB = 220;

  logic              clock = 1'b0;
  logic              reset;
  logic              send_signal;
  logic [NB*8-1:0]   send_data;
  logic              tx_full;
  logic              wr_uart;
  logic [7:0]        w_data;
  logic              data_sent;
  logic              busy;

  debugger_tx_serializer #(.NUM_BYTES(NB), .IDX_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .send_signal (send_signal),
    .send_data   (send_data),
    .tx_full     (tx_full),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .data_sent   (data_sent),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   write_cnt = 0;
  int   sent_cnt = 0;
  int   sent_cyc = -1;
  int   busy_fall = -1;
  int   ff_cnt = 0;
  logic full_at_edge = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_busy = 1'b0;

  // Falling-edge counter and tx_full as the DUT saw it on that edge.
  always @(negedge clock) begin
    cyc++;
    full_at_edge = tx_full;
  end

  // Scoreboard monitor.
  always @(posedge clock) begin
    if (wr_uart === 1'b1) begin
      write_cnt++;
      if (w_data == 8'hFF) ff_cnt++;
      vecs++;
      if (full_at_edge) begin
        $display("FAIL write_while_full: wr_uart=1 with tx_full=1 at edge %0d, required no write", cyc);
        errs++;
      end
      if (prev_wr) begin
        $display("FAIL back_to_back_write: writes on consecutive edges at %0d, required a gap", cyc);
        errs++;
      end
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: w_data=%02h at edge %0d, required no write", w_data, cyc);
        errs++;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (w_data !== e.b) begin
          $display("FAIL byte_value: got %02h, required %02h (edge %0d)", w_data, e.b, cyc);
          errs++;
        end
        if (e.t >= 0 && cyc !== e.t) begin
          $display("FAIL byte_timing: byte %02h at edge %0d, required edge %0d", w_data, cyc, e.t);
          errs++;
        end
      end
    end
    if (data_sent === 1'b1) begin
      sent_cnt++;
      sent_cyc = cyc;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
    prev_wr   = (wr_uart === 1'b1);
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one send_signal pulse and queue the frame's bytes.
  task automatic start_frame(input logic [NB*8-1:0] data, input bit timed);
    int k;
    send_data   = data;
    send_signal = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < NB; i++) begin
      exp_t e;
      e.b = data[i*8 +: 8];
      e.t = timed ? (k + 1 + 2 * i) : -1;
      exp_q.push_back(e);
    end
    tick();
    send_signal = 1'b0;
  endtask

  task automatic wait_sent(input int prev, input string name);
    int n = 0;
    while (sent_cnt == prev && n < 2000) begin
      tick();
      n++;
    end
    vecs++;
    if (sent_cnt == prev) begin
      $display("FAIL %s_timeout: no data_sent within 2000 cycles, required one", name);
      errs++;
    end
    repeat (4) tick();
  endtask

  task automatic wait_writes(input int target, input string name);
    int n = 0;
    while (write_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    if (write_cnt < target) begin
      vecs++;
      $display("FAIL %s_timeout: %0d writes, required %0d", name, write_cnt, target);
      errs++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; send_signal = 1'b1; tx_full = 1'b0; send_data = '1;
    repeat (3) tick();
    vecs++;
    if ({wr_uart, data_sent, busy} !== 3'b000 || w_data !== 8'h00) begin
      $display("FAIL reset_outputs: wr=%b sent=%b busy=%b w_data=%02h, required 0 0 0 00",
               wr_uart, data_sent, busy, w_data);
      errs++;
    end
    reset = 1'b0; send_signal = 1'b0;
    repeat (10) tick();
    vecs++;
    if (write_cnt !== 0 || busy !== 1'b0) begin
      $display("FAIL reset_idle: writes=%0d busy=%b, required 0 0", write_cnt, busy);
      errs++;
    end
  endtask

  task automatic test_full_frame();
    logic [NB*8-1:0] d;
    int k, w0, s0;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'(i);
    w0 = write_cnt; s0 = sent_cnt;
    k = cyc + 1;
    start_frame(d, 1'b1);
    wait_sent(s0, "full_frame");
    vecs++;
    if (write_cnt - w0 !== NB || exp_q.size() !== 0) begin
      $display("FAIL full_frame_count: writes=%0d left=%0d, required %0d 0", write_cnt - w0, exp_q.size(), NB);
      errs++;
    end
    vecs++;
    if (sent_cnt - s0 !== 1 || sent_cyc !== k + 441) begin
      $display("FAIL full_frame_sent: pulses=%0d at edge %0d, required 1 at %0d", sent_cnt - s0, sent_cyc, k + 441);
      errs++;
    end
    vecs++;
    if (busy_fall !== k + 441) begin
      $display("FAIL full_frame_busy: busy fell at edge %0d, required %0d", busy_fall, k + 441);
      errs++;
    end
  endtask

  task automatic test_backpressure();
    logic [NB*8-1:0] d;
    int w0, wf, s0;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'((i * 3 + 1) & 8'h7F);
    w0 = write_cnt; s0 = sent_cnt;
    start_frame(d, 1'b0);
    wait_writes(w0 + 5, "backpressure");
    tx_full = 1'b1;
    wf = write_cnt;
    repeat (10) tick();
    vecs++;
    if (write_cnt !== wf) begin
      $display("FAIL backpressure_stall: %0d writes while full, required 0", write_cnt - wf);
      errs++;
    end
    tx_full = 1'b0;
    wait_sent(s0, "backpressure");
    vecs++;
    if (write_cnt - w0 !== NB || exp_q.size() !== 0) begin
      $display("FAIL backpressure_count: writes=%0d left=%0d, required %0d 0", write_cnt - w0, exp_q.size(), NB);
      errs++;
    end
  endtask

  task automatic test_ignored_restart();
    logic [NB*8-1:0] d;
    int w0, s0, f0;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'((i * 7 + 3) & 8'h7F);
    w0 = write_cnt; s0 = sent_cnt; f0 = ff_cnt;
    start_frame(d, 1'b0);
    wait_writes(w0 + 50, "restart");
    send_data = '1; send_signal = 1'b1;
    tick();
    send_signal = 1'b0; send_data = {NB{8'hA5}};
    wait_sent(s0, "restart");
    repeat (20) tick();
    vecs++;
    if (sent_cnt - s0 !== 1 || ff_cnt !== f0) begin
      $display("FAIL restart_ignored: pulses=%0d ff_bytes=%0d, required 1 0", sent_cnt - s0, ff_cnt - f0);
      errs++;
    end
    vecs++;
    if (write_cnt - w0 !== NB || exp_q.size() !== 0 || busy !== 1'b0) begin
      $display("FAIL restart_count: writes=%0d left=%0d busy=%b, required %0d 0 0",
               write_cnt - w0, exp_q.size(), busy, NB);
      errs++;
    end
  endtask

  task automatic test_reset_mid();
    logic [NB*8-1:0] d;
    int w0, s0;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'(8'h80 | i[6:0]);
    w0 = write_cnt; s0 = sent_cnt;
    start_frame(d, 1'b0);
    wait_writes(w0 + 101, "reset_mid");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    w0 = write_cnt;
    repeat (30) tick();
    vecs++;
    if (write_cnt !== w0 || sent_cnt !== s0 || busy !== 1'b0 || w_data !== 8'h00) begin
      $display("FAIL reset_mid_abort: writes=%0d sent=%0d busy=%b w_data=%02h, required 0 0 0 00",
               write_cnt - w0, sent_cnt - s0, busy, w_data);
      errs++;
    end
    start_frame({NB{8'h32}}, 1'b0);
    wait_sent(s0, "reset_mid_new");
    vecs++;
    if (write_cnt - w0 !== NB || exp_q.size() !== 0) begin
      $display("FAIL reset_mid_new: writes=%0d left=%0d, required %0d 0", write_cnt - w0, exp_q.size(), NB);
      errs++;
    end
  endtask

  // Minimal behavioural stand-in for the command receiver: 0x31 launches a frame of 0x32.
  task automatic test_receiver();
    typedef enum int {WAITING, SENDING} rx_t;
    rx_t rx_state = WAITING;
    logic [7:0] cmd = 8'h31;
    int w0, s0, n;
    w0 = write_cnt; s0 = sent_cnt;
    if (cmd == 8'h31) begin
      rx_state = SENDING;
      start_frame({NB{8'h32}}, 1'b0);
    end
    n = 0;
    while (rx_state == SENDING && n < 2000) begin
      tick();
      if (sent_cnt != s0) rx_state = WAITING;
      n++;
    end
    repeat (4) tick();
    vecs++;
    if (rx_state !== WAITING) begin
      $display("FAIL receiver_return: receiver still SENDING after %0d cycles, required WAITING", n);
      errs++;
    end
    vecs++;
    if (write_cnt - w0 !== NB || exp_q.size() !== 0 || sent_cnt - s0 !== 1) begin
      $display("FAIL receiver_frame: writes=%0d left=%0d pulses=%0d, required %0d 0 1",
               write_cnt - w0, exp_q.size(), sent_cnt - s0, NB);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_ignored_restart();
    test_reset_mid();
    test_receiver();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/debugger_tx_serializer.md
Name: debugger_tx_serializer

Overview:
Downstream stage of the debugger command receiver. It latches a wide debug frame (NUM_BYTES bytes) when the receiver pulses send_signal, then writes the frame byte by byte into the UART transmitter FIFO, honouring tx_full. When the last byte has been written it pulses data_sent back to the receiver, which returns that block to its waiting state.

Parameters:
NUM_BYTES, 220, number of bytes per frame; send_data width is NUM_BYTES*8.
IDX_W, 8, width of the byte index counter; must satisfy 2**IDX_W >= NUM_BYTES.

Ports:
clock  input  1  system clock; all registers update on the falling edge.
reset  input  1  reset, synchronous, active-high.
send_signal  input  1  one-cycle frame-start pulse from the receiver.
send_data  input  NUM_BYTES*8  frame payload, sampled only on accepted send_signal.
tx_full  input  1  UART TX FIFO full; no write may be issued while it is 1.
wr_uart  output  1  one-cycle write strobe to the UART TX FIFO.
w_data  output  8  byte presented with wr_uart.
data_sent  output  1  one-cycle pulse; the frame is completely written.
busy  output  1  1 while a frame is in progress (SEND, GAP, DONE).

Behaviour:
- All outputs are registered. On reset: wr_uart=0, w_data=0, data_sent=0, busy=0, index=0, shadow frame=0, state=IDLE.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - If send_signal=1: shadow<=send_data, index<=0, busy<=1, go to SEND.
  - Otherwise hold, with wr_uart=0 and data_sent=0.
- SEND:
  - If tx_full=0: wr_uart<=1, w_data<=shadow[index*8+7 : index*8], go to GAP.
  - If tx_full=1: wr_uart<=0 and stay in SEND indefinitely. There is no timeout.
- GAP:
  - wr_uart<=0. This cycle gives tx_full time to reflect the write just made.
  - If index==NUM_BYTES-1, go to DONE. Otherwise index<=index+1 and go to SEND.
- DONE: data_sent<=1, busy<=0, go to IDLE. data_sent returns to 0 on the next edge.
- Byte order: byte 0 is send_data[7:0] and is transmitted first; byte NUM_BYTES-1 is transmitted last.
- w_data holds its last value when wr_uart=0.
- Each byte is written exactly once. There is no duplication or skipping under any tx_full pattern.
- Latency with tx_full=0 throughout, where send_signal is sampled at edge k:
  - byte i is written (wr_uart=1) at edge k+1+2i;
  - the last byte (NUM_BYTES=220) is written at edge k+439;
  - data_sent=1 from edge k+441 to edge k+442.
- Throughput: at most one byte every 2 cycles.
- send_signal while busy is ignored. The frame in progress continues unaffected and no second frame is queued.
- send_data changing after the latch has no effect.
- Simultaneous send_signal and data_sent in DONE: send_signal is ignored, because state is DONE rather than IDLE.
- Reset mid-frame takes priority over everything:
  - outputs return to reset values at that edge;
  - no further writes occur;
  - no data_sent is issued;
  - the partial frame is discarded.
- NUM_BYTES=1: SEND, GAP, DONE, with one write only.
- index never exceeds NUM_BYTES-1. There is no wrap-around.

Test Plan:
- Reset: hold reset 3 cycles with send_signal=1 -> wr_uart=0, data_sent=0, busy=0, w_data=0; no writes after release until a new send_signal.
- Full frame, no backpressure: send_data byte i = i (0x00..0xDB), pulse send_signal at edge k -> 220 writes of 0x00..0xDB in order at edges k+1+2i; single data_sent pulse at k+441; busy falls at k+441.
- Backpressure: raise tx_full for 10 cycles just before byte 5 -> no wr_uart during those 10 cycles; 0x05 written exactly once after release; remaining bytes in order; total writes = 220.
- Ignored restart: pulse send_signal again at byte 50 with send_data all 0xFF; change send_data mid-frame -> the original frame completes unchanged; exactly one data_sent; no 0xFF bytes written.
- Reset mid-frame: assert reset after byte 100 is written -> no further wr_uart; no data_sent; a new frame of replicated 0x32 then sends 220 bytes of 0x32 starting from byte 0.
- Receiver integration: the command receiver gets command byte 0x31 -> the frame is 220 copies of 0x32; 220 writes of 0x32; the receiver returns to WAITING after data_sent.
